// File: rtl/card_blitter.sv
// Card blitter: streams a 16x32 card bitmap from its memory into a 256x240 frame buffer at (posX, posY),
// clipping pixels that fall off the frame and skipping the transparent colour.
module card_blitter #(
    parameter bit         TRANSP_EN = 1'b1,
    parameter logic [2:0] TRANSP    = 3'b000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  posX,
    input  logic [7:0]  posY,
    output logic        cardRE,
    output logic [8:0]  cardAddr,
    input  logic [2:0]  cardData,
    output logic        fbWE,
    output logic [15:0] fbAddr,
    output logic [2:0]  fbData,
    output logic        busy,
    output logic        done
);

    localparam int unsigned AW      = 9;
    localparam int unsigned PW      = 3;
    localparam int unsigned CW      = 8;
    localparam int unsigned FBW     = 16;
    localparam int unsigned FB_ROWS = 240;
    localparam logic [AW-1:0] LAST_K = AW'(511);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            re_q, re_d;
    logic            drain_q, drain_d;
    logic [CW-1:0]   posx_q, posx_d;
    logic [CW-1:0]   posy_q, posy_d;
    logic            pvld_q, pvld_d;
    logic [AW-1:0]   pk_q, pk_d;
    logic            we_q, we_d;
    logic [FBW-1:0]  fbaddr_q, fbaddr_d;
    logic [PW-1:0]   fbdata_q, fbdata_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [CW:0]     x_c, y_c;

    // State and pipeline registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            re_q     <= 1'b0;
            drain_q  <= 1'b0;
            posx_q   <= '0;
            posy_q   <= '0;
            pvld_q   <= 1'b0;
            pk_q     <= '0;
            we_q     <= 1'b0;
            fbaddr_q <= '0;
            fbdata_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            re_q     <= re_d;
            drain_q  <= drain_d;
            posx_q   <= posx_d;
            posy_q   <= posy_d;
            pvld_q   <= pvld_d;
            pk_q     <= pk_d;
            we_q     <= we_d;
            fbaddr_q <= fbaddr_d;
            fbdata_q <= fbdata_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Next-state logic; memory-side outputs are computed one cycle ahead so they stay registered
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        re_d     = 1'b0;
        drain_d  = drain_q;
        posx_d   = posx_q;
        posy_d   = posy_q;
        pvld_d   = re_q;
        pk_d     = addr_q;
        we_d     = 1'b0;
        fbaddr_d = fbaddr_q;
        fbdata_d = fbdata_q;
        x_c      = {1'b0, posx_q} + (CW+1)'(pk_q[3:0]);
        y_c      = {1'b0, posy_q} + (CW+1)'(pk_q[8:4]);

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    posx_d  = posX;
                    posy_d  = posY;
                    addr_d  = '0;
                    re_d    = 1'b1;
                end
            end
            RUN: begin
                if (addr_q == LAST_K) begin
                    state_d = DRAIN;
                    drain_d = 1'b0;
                end else begin
                    addr_d = addr_q + AW'(1);
                    re_d   = 1'b1;
                end
            end
            DRAIN: begin
                if (drain_q) begin
                    state_d = DONE;
                end else begin
                    drain_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Pixel stage: card data for pk_q arrives this cycle, paired with its delayed index
        if (pvld_q) begin
            fbaddr_d = {y_c[CW-1:0], x_c[CW-1:0]};
            fbdata_d = cardData;
            we_d     = !x_c[CW] && (y_c < (CW+1)'(FB_ROWS))
                       && !(TRANSP_EN && (cardData == TRANSP));
        end

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    assign cardRE   = re_q;
    assign cardAddr = addr_q;
    assign fbWE     = we_q;
    assign fbAddr   = fbaddr_q;
    assign fbData   = fbdata_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_card_blitter.sv
// Bench for card_blitter: directed and random draws checked cycle by cycle against a pixel-level
// reference computed straight from the card geometry and clipping rules.
module tb_card_blitter;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  posX, posY;
    logic        cardRE;
    logic [8:0]  cardAddr;
    logic [2:0]  cardData = 3'd0;
    logic        fbWE;
    logic [15:0] fbAddr;
    logic [2:0]  fbData;
    logic        busy, done;

    logic [2:0]  mem [512];
    int n_cmp = 0;
    int n_err = 0;
    int wr_cnt, done_cnt, first_addr;

    card_blitter dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .posX    (posX),
        .posY    (posY),
        .cardRE  (cardRE),
        .cardAddr(cardAddr),
        .cardData(cardData),
        .fbWE    (fbWE),
        .fbAddr  (fbAddr),
        .fbData  (fbData),
        .busy    (busy),
        .done    (done)
    );

    always #5 clock = ~clock;

    // Card memory with one cycle of read latency
    always @(posedge clock) begin
        if (cardRE) cardData <= mem[cardAddr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " busy"},     32'(busy),     32'd0);
        chk({tag, " done"},     32'(done),     32'd0);
        chk({tag, " cardRE"},   32'(cardRE),   32'd0);
        chk({tag, " cardAddr"}, 32'(cardAddr), 32'd0);
        chk({tag, " fbWE"},     32'(fbWE),     32'd0);
        chk({tag, " fbAddr"},   32'(fbAddr),   32'd0);
        chk({tag, " fbData"},   32'(fbData),   32'd0);
    endtask

    // One draw, cycle 0 being the first RUN cycle; optional extra start pulse in cycle 'second'
    task automatic run_draw(input int px, input int py, input int second);
        int k, x, y;
        bit ew;
        wr_cnt = 0;
        done_cnt = 0;
        first_addr = -1;
        @(negedge clock);
        posX = 8'(px);
        posY = 8'(py);
        start = 1'b1;
        for (int c = 0; c < 520; c++) begin
            @(posedge clock);
            #1;
            start = (c == second);
            posX = 8'($urandom);
            posY = 8'($urandom);
            @(negedge clock);
            chk($sformatf("busy c%0d", c), 32'(busy), 32'(c <= 514));
            chk($sformatf("done c%0d", c), 32'(done), 32'(c == 514));
            if (done === 1'b1) done_cnt++;
            chk($sformatf("cardRE c%0d", c), 32'(cardRE), 32'(c <= 511));
            if (c <= 511) chk($sformatf("cardAddr c%0d", c), 32'(cardAddr), 32'(c));
            ew = 1'b0;
            k = c - 2;
            x = 0;
            y = 0;
            if (c >= 2 && c <= 513) begin
                x = px + (k % 16);
                y = py + (k / 16);
                ew = (x <= 255) && (y < 240) && (mem[k] != 3'd0);
            end
            chk($sformatf("fbWE c%0d", c), 32'(fbWE), 32'(ew));
            if (fbWE === 1'b1) begin
                wr_cnt++;
                if (first_addr < 0) first_addr = int'(fbAddr);
            end
            if (ew && fbWE === 1'b1) begin
                chk($sformatf("fbAddr k%0d", k), 32'(fbAddr), 32'(y * 256 + x));
                chk($sformatf("fbData k%0d", k), 32'(fbData), 32'(mem[k]));
            end
        end
        start = 1'b0;
    endtask

    initial begin
        int px, py, wr_seen, done_seen, busy_seen;
        reset = 1'b1;
        start = 1'b0;
        posX  = 8'd0;
        posY  = 8'd0;
        for (int i = 0; i < 512; i++) mem[i] = 3'd0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk_reset_outputs("por");
        reset = 1'b0;
        repeat (2) @(negedge clock);
        chk("idle busy", 32'(busy), 32'd0);

        // Full card at origin
        for (int i = 0; i < 512; i++) mem[i] = 3'd5;
        run_draw(0, 0, -1);
        chk("origin writes", 32'(wr_cnt), 32'd512);
        chk("origin done", 32'(done_cnt), 32'd1);
        chk("origin first", 32'(first_addr), 32'h0000);

        // Clipped at the right and bottom edges
        for (int i = 0; i < 512; i++) mem[i] = 3'd1;
        run_draw(250, 230, -1);
        chk("clip writes", 32'(wr_cnt), 32'd60);
        chk("clip first", 32'(first_addr), 32'hE6FA);

        // Transparent checkerboard
        for (int i = 0; i < 512; i++) mem[i] = (((i % 16) + (i / 16)) % 2 != 0) ? 3'd7 : 3'd0;
        run_draw(17, 40, -1);
        chk("checker writes", 32'(wr_cnt), 32'd256);

        // Start while busy is ignored
        for (int i = 0; i < 512; i++) mem[i] = 3'($urandom_range(0, 7));
        run_draw(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 10);
        chk("restart done count", 32'(done_cnt), 32'd1);
        repeat (2) @(negedge clock);
        chk("restart idle busy", 32'(busy), 32'd0);

        // Random images and positions, biased toward the frame edges
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < 512; i++) mem[i] = 3'($urandom_range(0, 7));
            px = (t % 2 == 0) ? int'($urandom_range(230, 255)) : int'($urandom_range(0, 255));
            py = (t % 2 == 0) ? int'($urandom_range(200, 255)) : int'($urandom_range(0, 255));
            run_draw(px, py, -1);
            chk($sformatf("rand%0d done", t), 32'(done_cnt), 32'd1);
        end

        // Reset in the middle of a draw
        for (int i = 0; i < 512; i++) mem[i] = 3'd5;
        @(negedge clock);
        posX = 8'd0;
        posY = 8'd0;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (100) @(posedge clock);
        #2;
        chk("mid busy", 32'(busy), 32'd1);
        chk("mid cardAddr", 32'(cardAddr), 32'd100);
        reset = 1'b1;
        #1;
        chk_reset_outputs("async");
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        wr_seen = 0;
        done_seen = 0;
        busy_seen = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clock);
            if (fbWE === 1'b1) wr_seen++;
            if (done === 1'b1) done_seen++;
            if (busy !== 1'b0) busy_seen++;
        end
        chk("abort writes", 32'(wr_seen), 32'd0);
        chk("abort done", 32'(done_seen), 32'd0);
        chk("abort busy", 32'(busy_seen), 32'd0);
        run_draw(3, 7, -1);
        chk("post-reset writes", 32'(wr_cnt), 32'd512);
        chk("post-reset done", 32'(done_cnt), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/card_blitter.md
CARD_BLITTER -- requirements
Module: card_blitter

Interface
REQ-001 Parameter TRANSP_EN, default 1: when 1, pixels equal to TRANSP are not written.
REQ-002 Parameter TRANSP, default 3'b000: 3-bit transparent colour code.
REQ-003 clock  in  1  single clock for all state; all registers update on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  request to draw one card; sampled only in IDLE.
REQ-006 posX  in  8  frame-buffer column of the card's top-left pixel.
REQ-007 posY  in  8  frame-buffer row of the card's top-left pixel.
REQ-008 cardRE  out  1  read enable to the 512x3 card bitmap memory.
REQ-009 cardAddr  out  9  read address to the card memory; data returns one cycle later.
REQ-010 cardData  in  3  card memory read data; valid the cycle after cardRE/cardAddr.
REQ-011 fbWE  out  1  frame-buffer write enable.
REQ-012 fbAddr  out  16  frame-buffer address {row[7:0], col[7:0]} (256x240).
REQ-013 fbData  out  3  frame-buffer write pixel.
REQ-014 busy  out  1  high while a draw is in progress.
REQ-015 done  out  1  one-cycle pulse when a draw completes.

Function
REQ-016 The card image is 16 columns x 32 rows; pixel index k (0..511) maps to col = k[3:0] and row = k[8:4].
REQ-017 The FSM has exactly four states: IDLE, RUN, DRAIN, DONE.
REQ-018 IDLE -> RUN when start=1 on a clock edge; posX/posY are latched on that edge, and k is cleared to 0.
REQ-019 In RUN, cardRE=1 and cardAddr=k every cycle; k increments by 1 per cycle; RUN -> DRAIN after the cycle issuing k=511.
REQ-020 DRAIN lasts exactly 2 cycles with cardRE=0; then DRAIN -> DONE.
REQ-021 DONE lasts exactly 1 cycle with done=1; then DONE -> IDLE.
REQ-022 busy=1 in RUN, DRAIN and DONE; busy=0 in IDLE.
REQ-023 start is ignored while busy=1; no request is queued.
REQ-024 Latency: pixel k is issued on cardAddr in cycle T; cardData for it is valid in T+1; its fbWE/fbAddr/fbData appear as registered outputs in T+2.
REQ-025 Pixel k targets x = posX + col and y = posY + row, both computed 9 bits wide.
REQ-026 The write for pixel k is suppressed (fbWE=0) if x > 255, or y >= 240, or (TRANSP_EN=1 and cardData == TRANSP).
REQ-027 When the write is not suppressed: fbWE=1, fbAddr={y[7:0], x[7:0]}, fbData=cardData.
REQ-028 fbWE=0 in every cycle that carries no valid pixel, including IDLE, DONE and the first RUN cycle.
REQ-029 A full draw takes exactly 515 cycles from the first RUN cycle to the DONE cycle inclusive.
REQ-030 done rises in the cycle after the last possible fbWE cycle (pixel 511).
REQ-031 cardAddr holds its last value when cardRE=0.
REQ-032 fbAddr and fbData are don't-care when fbWE=0.

Reset
REQ-033 reset=1 forces IDLE immediately, independent of clock.
REQ-034 During reset: busy=0, done=0, cardRE=0, cardAddr=0, fbWE=0, fbAddr=0, fbData=0, k=0.
REQ-035 A reset asserted mid-draw aborts the draw: no further fbWE pulses and no done pulse.
REQ-036 After reset deassertion the block waits in IDLE for a new start.

Verification
REQ-037 Memory all 3'b101, posX=0, posY=0, start pulse -> 512 writes to addresses row*256+col (0x0000..0x1F0F), each fbData=5, then done pulse, busy high for 515 cycles.
REQ-038 posX=250, posY=230, memory all 3'b001 -> writes only for col 0..5 and row 0..9 (60 writes); first write to 0xE6FA; no write whose x or y wraps.
REQ-039 TRANSP_EN=1, TRANSP=0, checkerboard 0/7 memory -> exactly 256 writes, all with fbData=7.
REQ-040 Second start pulse 10 cycles after the first -> ignored; exactly one done pulse, 515 cycles after the first RUN cycle.
REQ-041 reset asserted at cycle 100 of RUN -> outputs reach their reset values asynchronously; no done; a subsequent start performs a complete 515-cycle draw.
REQ-042 cardData driven by a model with 1-cycle read latency -> fbData for pixel k equals mem[k] exactly 2 cycles after cardAddr=k.
